// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and sizing helper for the modulo up/down counter
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Prescaler counter width: max(1, clog2(p)) so PRESCALE=1 still has a legal vector.
    function automatic int prescale_width(input int p);
        int w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// rtl/prescaler_tick.sv - enabled divide-by-PRESCALE strobe generator with synchronous restart
module prescaler_tick
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// rtl/counter_mod_updown.sv - prescaled modulo up/down counter with load, clear, wrap pulse and compare match
// Define COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODULO   = 16,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] cmp_val,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         match
);

    localparam int NW = N + 1;
    localparam logic [N-1:0]  MAX_VAL = N'(MODULO - 1);
    localparam logic [NW-1:0] MOD_EXT = NW'(MODULO);

    if (MODULO < 2 || MODULO > (2 ** N)) begin : g_bad_modulo
        $error("counter_mod_updown: MODULO must satisfy 2 <= MODULO <= 2**N");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_mod_updown: PRESCALE must be >= 1");
    end

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         step;
    dir_t         dir;

    assign dir = dir_t'(up);

    // Clear and load both restart the prescaler phase.
    prescaler_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (clear | load),
        .tick     (step)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
`ifdef COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = MAX_VAL;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign match = (count_q == cmp_val);

endmodule
